// File: rtl/cc_obstacle_scroller.sv
// Obstacle field generator for the LED-matrix game: spawns LFSR rows, scrolls them
// down on a prescaled tick that speeds up with the level, and freezes on collision.
module cc_obstacle_scroller #(
    parameter int         NUMBER_DATAWIDTH = 8,
    parameter int         PRESCALER_WIDTH  = 26,
    parameter int         INITIAL_PERIOD   = 24999999,
    parameter int         MIN_PERIOD       = 4999999,
    parameter int         PERIOD_STEP      = 2500000,
    parameter int         LEVEL_ROWS       = 8,
    parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
    input  logic                        CC_OBSTACLE_SCROLLER_CLOCK_50,
    input  logic                        CC_OBSTACLE_SCROLLER_RESET_InHigh,
    input  logic                        CC_OBSTACLE_SCROLLER_enable_In,
    input  logic                        CC_OBSTACLE_SCROLLER_clear_In,
    input  logic                        CC_OBSTACLE_SCROLLER_collision_In,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila7_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila6_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila5_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila4_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila3_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila2_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila1_OutBUS,
    output logic [NUMBER_DATAWIDTH-1:0] CC_OBSTACLE_SCROLLER_fila0_OutBUS,
    output logic                        CC_OBSTACLE_SCROLLER_tick_Out,
    output logic [7:0]                  CC_OBSTACLE_SCROLLER_score_OutBUS,
    output logic [3:0]                  CC_OBSTACLE_SCROLLER_level_OutBUS,
    output logic                        CC_OBSTACLE_SCROLLER_frozen_Out
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, FROZEN} stateT;

    typedef struct packed {
        stateT                                state;
        logic [7:0][NUMBER_DATAWIDTH-1:0]     rows;
        logic [7:0]                           score;
        logic [3:0]                           level;
        logic [PRESCALER_WIDTH-1:0]           period;
        logic [PRESCALER_WIDTH-1:0]           prescaler;
        logic [7:0]                           lfsr;
        logic                                 phase;
        logic                                 tick;
    } regsT;

    localparam logic [PRESCALER_WIDTH-1:0] INIT_P = PRESCALER_WIDTH'(INITIAL_PERIOD);
    localparam logic [PRESCALER_WIDTH-1:0] MIN_P  = PRESCALER_WIDTH'(MIN_PERIOD);
    localparam logic [PRESCALER_WIDTH-1:0] STEP_P = PRESCALER_WIDTH'(PERIOD_STEP);
    localparam logic [PRESCALER_WIDTH:0]   FLOOR_TRIGGER = (PRESCALER_WIDTH+1)'(MIN_PERIOD + PERIOD_STEP);

    localparam regsT RESET_REGS = '{
        state: IDLE, rows: '0, score: '0, level: '0, period: INIT_P,
        prescaler: '0, lfsr: LFSR_SEED, phase: 1'b0, tick: 1'b0
    };

    regsT cur;
    regsT nxt;

    logic                        tickFire;
    logic                        scoreInc;
    logic                        levelUp;
    logic [7:0]                  scoreNext;
    logic [7:0]                  lfsrShift;
    logic [NUMBER_DATAWIDTH-1:0] spawnRow;

    // NOTE: clear is synchronous, so it sits in the clocked branch rather than the sensitivity list.
    always_ff @(posedge CC_OBSTACLE_SCROLLER_CLOCK_50 or posedge CC_OBSTACLE_SCROLLER_RESET_InHigh) begin
        if (CC_OBSTACLE_SCROLLER_RESET_InHigh) begin
            cur <= RESET_REGS;
        end else if (CC_OBSTACLE_SCROLLER_clear_In) begin
            cur <= RESET_REGS;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge state together.
            cur <= nxt;
        end
    end

    // Spawned row always keeps the column selected by lfsr[2:0] open.
    assign spawnRow  = NUMBER_DATAWIDTH'(cur.lfsr & ~(8'd1 << cur.lfsr[2:0]));
    assign lfsrShift = {cur.lfsr[6:0], cur.lfsr[7] ^ cur.lfsr[5] ^ cur.lfsr[4] ^ cur.lfsr[3]};
    assign tickFire  = (cur.state == RUN) && !CC_OBSTACLE_SCROLLER_collision_In
                       && (cur.prescaler == cur.period);
    assign scoreInc  = (cur.rows[0] != '0) && (cur.score != 8'hFF);
    assign scoreNext = cur.score + 8'd1;
    assign levelUp   = scoreInc && ((int'(scoreNext) % LEVEL_ROWS) == 0) && (cur.level != 4'hF);

    // NOTE: nxt defaults to cur first, so every path assigns every field and no latch is inferred.
    always_comb begin
        nxt      = cur;
        nxt.tick = tickFire;

        unique case (cur.state)
            IDLE:    if (CC_OBSTACLE_SCROLLER_enable_In) nxt.state = RUN;
            RUN:     if (CC_OBSTACLE_SCROLLER_collision_In) nxt.state = FROZEN;
                     else if (!CC_OBSTACLE_SCROLLER_enable_In) nxt.state = PAUSE;
            PAUSE:   if (CC_OBSTACLE_SCROLLER_collision_In) nxt.state = FROZEN;
                     else if (CC_OBSTACLE_SCROLLER_enable_In) nxt.state = RUN;
            default: nxt.state = cur.state;
        endcase

        if (cur.state == RUN && !CC_OBSTACLE_SCROLLER_collision_In) begin
            nxt.prescaler = tickFire ? '0 : cur.prescaler + 1'b1;
        end

        if (tickFire) begin
            nxt.rows  = {(cur.phase ? '0 : spawnRow), cur.rows[7:1]};
            nxt.phase = ~cur.phase;
            if (!cur.phase) nxt.lfsr = (lfsrShift == 8'd0) ? LFSR_SEED : lfsrShift;
            if (scoreInc) nxt.score = scoreNext;
            if (levelUp) begin
                nxt.level  = cur.level + 4'd1;
                nxt.period = ({1'b0, cur.period} >= FLOOR_TRIGGER) ? cur.period - STEP_P : MIN_P;
            end
        end
    end

    assign CC_OBSTACLE_SCROLLER_fila7_OutBUS  = cur.rows[7];
    assign CC_OBSTACLE_SCROLLER_fila6_OutBUS  = cur.rows[6];
    assign CC_OBSTACLE_SCROLLER_fila5_OutBUS  = cur.rows[5];
    assign CC_OBSTACLE_SCROLLER_fila4_OutBUS  = cur.rows[4];
    assign CC_OBSTACLE_SCROLLER_fila3_OutBUS  = cur.rows[3];
    assign CC_OBSTACLE_SCROLLER_fila2_OutBUS  = cur.rows[2];
    assign CC_OBSTACLE_SCROLLER_fila1_OutBUS  = cur.rows[1];
    assign CC_OBSTACLE_SCROLLER_fila0_OutBUS  = cur.rows[0];
    assign CC_OBSTACLE_SCROLLER_tick_Out      = cur.tick;
    assign CC_OBSTACLE_SCROLLER_score_OutBUS  = cur.score;
    assign CC_OBSTACLE_SCROLLER_level_OutBUS  = cur.level;
    assign CC_OBSTACLE_SCROLLER_frozen_Out    = (cur.state == FROZEN);

endmodule
